// File: rtl/wb_cpu_bus_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone B3 arbiter with whole-cycle grant.
// Optional bus watchdog with ABORT state is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_cpu_bus_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [ADDRESS_WIDTH-1:0]  iwbs_adr_i,
  input  logic [DATA_WIDTH-1:0]     iwbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   iwbs_sel_i,
  input  logic                      iwbs_we_i,
  input  logic [2:0]                iwbs_cti_i,
  input  logic                      iwbs_cyc_i,
  input  logic                      iwbs_stb_i,
  output logic [DATA_WIDTH-1:0]     iwbs_dat_o,
  output logic                      iwbs_ack_o,
  output logic                      iwbs_err_o,
  output logic                      iwbs_rty_o,
  input  logic [ADDRESS_WIDTH-1:0]  dwbs_adr_i,
  input  logic [DATA_WIDTH-1:0]     dwbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   dwbs_sel_i,
  input  logic                      dwbs_we_i,
  input  logic [2:0]                dwbs_cti_i,
  input  logic                      dwbs_cyc_i,
  input  logic                      dwbs_stb_i,
  output logic [DATA_WIDTH-1:0]     dwbs_dat_o,
  output logic                      dwbs_ack_o,
  output logic                      dwbs_err_o,
  output logic                      dwbs_rty_o,
  output logic [ADDRESS_WIDTH-1:0]  wbm_adr_o,
  output logic [DATA_WIDTH-1:0]     wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0]   wbm_sel_o,
  output logic                      wbm_we_o,
  output logic [2:0]                wbm_cti_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  input  logic [DATA_WIDTH-1:0]     wbm_dat_i,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i,
  input  logic                      wbm_rty_i,
  output logic [1:0]                grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } state_t;

  state_t state;
  logic   last_d;
  logic   data_wins;
  logic   term;
  logic   timeout;
  logic   on_i;
  logic   on_d;

  assign term      = wbm_ack_i | wbm_err_i | wbm_rty_i;
  // last_d resets to 0 (instruction last), so data wins the first round-robin tie
  assign data_wins = (DATA_PRIORITY != 0) || !last_d;
  assign on_i      = (state == GNT_I) && !timeout;
  assign on_d      = (state == GNT_D) && !timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             granted;
  logic             release_now;

  assign granted     = (state == GNT_I) || (state == GNT_D);
  assign release_now = ((state == GNT_I) && !iwbs_cyc_i) || ((state == GNT_D) && !dwbs_cyc_i);
  assign timeout     = granted && (cnt == CNT_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (!granted || release_now || term) begin
      cnt <= '0;
    end else if (wbm_stb_o) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      grant_o <= 2'b00;
      last_d  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dwbs_cyc_i && (!iwbs_cyc_i || data_wins)) begin
            state   <= GNT_D;
            grant_o <= 2'b10;
            last_d  <= 1'b1;
          end else if (iwbs_cyc_i) begin
            state   <= GNT_I;
            grant_o <= 2'b01;
            last_d  <= 1'b0;
          end
        end
        GNT_I: begin
`ifdef WB_ARB_TIMEOUT_EN
          if (timeout) begin
            state   <= ABORT;
            grant_o <= 2'b00;
          end else
`endif
          if (!iwbs_cyc_i) begin
            if (dwbs_cyc_i) begin
              state   <= GNT_D;
              grant_o <= 2'b10;
              last_d  <= 1'b1;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        GNT_D: begin
`ifdef WB_ARB_TIMEOUT_EN
          if (timeout) begin
            state   <= ABORT;
            grant_o <= 2'b00;
          end else
`endif
          if (!dwbs_cyc_i) begin
            if (iwbs_cyc_i) begin
              state   <= GNT_I;
              grant_o <= 2'b01;
              last_d  <= 1'b0;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        // last_d still names the aborted master; wait for it to end its cycle
        ABORT: begin
          if (!(last_d ? dwbs_cyc_i : iwbs_cyc_i)) state <= IDLE;
        end
`endif
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_we_o  = 1'b0;
    wbm_cti_o = 3'b000;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    if (on_i) begin
      wbm_adr_o = iwbs_adr_i;
      wbm_dat_o = iwbs_dat_i;
      wbm_sel_o = iwbs_sel_i;
      wbm_we_o  = iwbs_we_i;
      wbm_cti_o = iwbs_cti_i;
      wbm_cyc_o = iwbs_cyc_i;
      wbm_stb_o = iwbs_stb_i;
    end else if (on_d) begin
      wbm_adr_o = dwbs_adr_i;
      wbm_dat_o = dwbs_dat_i;
      wbm_sel_o = dwbs_sel_i;
      wbm_we_o  = dwbs_we_i;
      wbm_cti_o = dwbs_cti_i;
      wbm_cyc_o = dwbs_cyc_i;
      wbm_stb_o = dwbs_stb_i;
    end
  end

  assign iwbs_dat_o = wbm_dat_i;
  assign dwbs_dat_o = wbm_dat_i;
  assign iwbs_ack_o = on_i & wbm_ack_i;
  assign iwbs_rty_o = on_i & wbm_rty_i;
  assign iwbs_err_o = (on_i & wbm_err_i) | ((state == GNT_I) & timeout);
  assign dwbs_ack_o = on_d & wbm_ack_i;
  assign dwbs_rty_o = on_d & wbm_rty_i;
  assign dwbs_err_o = (on_d & wbm_err_i) | ((state == GNT_D) & timeout);

endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
// Bench for wb_cpu_bus_arbiter: instance 0 uses data priority, instance 1 round-robin.
// Timeout sequence runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_cpu_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] i_adr, i_dat, d_adr, d_dat, s_dat;
  logic [3:0]  i_sel, d_sel;
  logic [2:0]  i_cti, d_cti;
  logic i_we, d_we, i_cyc, i_stb, d_cyc, d_stb, s_ack, s_err, s_rty;

  logic [31:0] o_idat [2], o_ddat [2], o_adr [2], o_dat [2];
  logic [3:0]  o_sel [2];
  logic [2:0]  o_cti [2];
  logic [1:0]  o_grant [2];
  logic o_iack [2], o_ierr [2], o_irty [2], o_dack [2], o_derr [2], o_drty [2];
  logic o_we [2], o_cyc [2], o_stb [2];

  int checks = 0;
  int errors = 0;
  int own [2], last [2], streak [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_cpu_bus_arbiter #(
      .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
      .DATA_PRIORITY(g == 0 ? 1 : 0), .TIMEOUT_CYCLES(8)
    ) u_dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .iwbs_adr_i(i_adr), .iwbs_dat_i(i_dat), .iwbs_sel_i(i_sel), .iwbs_we_i(i_we),
      .iwbs_cti_i(i_cti), .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb),
      .iwbs_dat_o(o_idat[g]), .iwbs_ack_o(o_iack[g]), .iwbs_err_o(o_ierr[g]), .iwbs_rty_o(o_irty[g]),
      .dwbs_adr_i(d_adr), .dwbs_dat_i(d_dat), .dwbs_sel_i(d_sel), .dwbs_we_i(d_we),
      .dwbs_cti_i(d_cti), .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb),
      .dwbs_dat_o(o_ddat[g]), .dwbs_ack_o(o_dack[g]), .dwbs_err_o(o_derr[g]), .dwbs_rty_o(o_drty[g]),
      .wbm_adr_o(o_adr[g]), .wbm_dat_o(o_dat[g]), .wbm_sel_o(o_sel[g]), .wbm_we_o(o_we[g]),
      .wbm_cti_o(o_cti[g]), .wbm_cyc_o(o_cyc[g]), .wbm_stb_o(o_stb[g]),
      .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty),
      .grant_o(o_grant[g])
    );
  end

  // Reference model: owner 0 = none, 1 = instruction, 2 = data
  function automatic logic [145:0] exp_vec(int j);
    logic [1:0] g; logic c, s, w; logic [2:0] t, ir, dr; logic [3:0] sl; logic [31:0] a, dt;
    g = 2'b00; c = 0; s = 0; w = 0; t = 0; sl = 0; a = 0; dt = 0; ir = 0; dr = 0;
    if (own[j] == 1) begin
      g = 2'b01; c = i_cyc; s = i_stb; w = i_we; t = i_cti; sl = i_sel; a = i_adr; dt = i_dat;
      ir = {s_ack, s_err, s_rty};
    end else if (own[j] == 2) begin
      g = 2'b10; c = d_cyc; s = d_stb; w = d_we; t = d_cti; sl = d_sel; a = d_adr; dt = d_dat;
      dr = {s_ack, s_err, s_rty};
    end
    return {g, c, s, w, t, sl, a, dt, ir, dr, s_dat, s_dat};
  endfunction

  function automatic logic [145:0] act_vec(int j);
    return {o_grant[j], o_cyc[j], o_stb[j], o_we[j], o_cti[j], o_sel[j], o_adr[j], o_dat[j],
            o_iack[j], o_ierr[j], o_irty[j], o_dack[j], o_derr[j], o_drty[j], o_idat[j], o_ddat[j]};
  endfunction

  task automatic check_model(string tag);
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (act_vec(j) !== exp_vec(j)) begin
        errors++;
        $display("FAIL %s dut%0d got %h want %h", tag, j, act_vec(j), exp_vec(j));
      end
    end
  endtask

  task automatic check(string tag, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, want);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      own[j] = 0; last[j] = 1; streak[j] = 0;
    end
  endtask

  task automatic model_step();
    int n;
    bit stbx, term;
    if (!rst_n) begin
      model_reset();
      return;
    end
    term = s_ack | s_err | s_rty;
    for (int j = 0; j < 2; j++) begin
      stbx = (own[j] == 1) ? i_stb : (own[j] == 2) ? d_stb : 1'b0;
      streak[j] = (own[j] == 0 || term) ? 0 : streak[j] + int'(stbx);
      n = own[j];
      if (own[j] == 0) begin
        if (i_cyc && d_cyc) n = (j == 0 || last[j] == 1) ? 2 : 1;
        else if (i_cyc) n = 1;
        else if (d_cyc) n = 2;
      end else if (own[j] == 1 && !i_cyc) begin
        n = d_cyc ? 2 : 0;
      end else if (own[j] == 2 && !d_cyc) begin
        n = i_cyc ? 1 : 0;
      end
      if (n != 0) last[j] = n;
      own[j] = n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0; s_ack = 0; s_err = 0; s_rty = 0;
    i_cti = 0; d_cti = 0; i_we = 0; d_we = 0;
  endtask

  typedef struct {
    logic ic, is, dc, ds, ack;
    logic [2:0] icti;
    logic [1:0] gp, gr;
    logic iack, dack, cyc;
    logic [2:0] cti;
    logic [31:0] adr;
  } row_t;

  function automatic row_t mk(logic ic, logic is, logic dc, logic ds, logic ack, logic [2:0] icti,
                              logic [1:0] gp, logic [1:0] gr, logic iack, logic dack, logic cyc,
                              logic [2:0] cti, logic [31:0] adr);
    row_t r;
    r.ic = ic; r.is = is; r.dc = dc; r.ds = ds; r.ack = ack; r.icti = icti;
    r.gp = gp; r.gr = gr; r.iack = iack; r.dack = dack; r.cyc = cyc; r.cti = cti; r.adr = adr;
    return r;
  endfunction

  row_t tbl [28];

  initial begin
    tbl[0]  = mk(1,1,0,0,0,0, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[1]  = mk(1,1,0,0,1,0, 2'b01,2'b01,1,0,1,0,32'h100);
    tbl[2]  = mk(0,0,0,0,0,0, 2'b01,2'b01,0,0,0,0,32'h100);
    tbl[3]  = mk(0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[4]  = mk(1,1,1,1,0,0, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[5]  = mk(1,1,1,1,1,0, 2'b10,2'b10,0,1,1,0,32'h200);
    tbl[6]  = mk(1,1,0,0,0,0, 2'b10,2'b10,0,0,0,0,32'h200);
    tbl[7]  = mk(1,1,1,1,1,0, 2'b01,2'b01,1,0,1,0,32'h100);
    tbl[8]  = mk(0,0,1,1,0,0, 2'b01,2'b01,0,0,0,0,32'h100);
    tbl[9]  = mk(1,1,1,1,0,0, 2'b10,2'b10,0,0,1,0,32'h200);
    tbl[10] = mk(1,1,0,0,0,0, 2'b10,2'b10,0,0,0,0,32'h200);
    tbl[11] = mk(0,0,0,0,0,0, 2'b01,2'b01,0,0,0,0,32'h100);
    tbl[12] = mk(0,0,1,1,0,0, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[13] = mk(0,0,0,0,0,0, 2'b10,2'b10,0,0,0,0,32'h200);
    tbl[14] = mk(0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[15] = mk(1,1,1,1,0,0, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[16] = mk(1,1,1,1,0,0, 2'b10,2'b01,0,0,1,0,32'h200);
    tbl[17] = mk(0,0,0,0,0,0, 2'b10,2'b01,0,0,0,0,32'h200);
    tbl[18] = mk(0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[19] = mk(1,1,0,0,0,2, 2'b00,2'b00,0,0,0,0,32'h0);
    tbl[20] = mk(1,1,0,0,1,2, 2'b01,2'b01,1,0,1,2,32'h100);
    tbl[21] = mk(1,1,1,1,1,2, 2'b01,2'b01,1,0,1,2,32'h100);
    tbl[22] = mk(1,1,1,1,1,2, 2'b01,2'b01,1,0,1,2,32'h100);
    tbl[23] = mk(1,1,1,1,1,7, 2'b01,2'b01,1,0,1,7,32'h100);
    tbl[24] = mk(0,0,1,1,0,0, 2'b01,2'b01,0,0,0,0,32'h100);
    tbl[25] = mk(0,0,1,1,1,0, 2'b10,2'b10,0,1,1,0,32'h200);
    tbl[26] = mk(0,0,0,0,0,0, 2'b10,2'b10,0,0,0,0,32'h200);
    tbl[27] = mk(0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0,32'h0);

    rst_n = 0;
    clear_inputs();
    i_adr = 32'h100; d_adr = 32'h200; i_dat = 32'h1111_0000; d_dat = 32'h2222_0000;
    i_sel = 4'hf; d_sel = 4'h3; s_dat = 32'h0;
    model_reset();
    @(negedge clk);
    check_model("reset_state");
    tick();
    tick();
    rst_n = 1;

    for (int k = 0; k < 28; k++) begin
      i_cyc = tbl[k].ic; i_stb = tbl[k].is; d_cyc = tbl[k].dc; d_stb = tbl[k].ds;
      s_ack = tbl[k].ack; i_cti = tbl[k].icti; d_cti = 3'b000;
      s_dat = 32'hA500_0000 + k;
      @(negedge clk);
      check($sformatf("vec%0d", k),
            {22'd0, o_grant[0], o_grant[1], o_iack[0], o_dack[0], o_cyc[0], o_cti[0], o_adr[0]},
            {22'd0, tbl[k].gp, tbl[k].gr, tbl[k].iack, tbl[k].dack, tbl[k].cyc, tbl[k].cti, tbl[k].adr});
      check_model($sformatf("vec%0d_model", k));
      tick();
    end

    // Reset asserted mid-burst, data request pending across reset release
    clear_inputs();
    i_cyc = 1; i_stb = 1; i_cti = 3'b010;
    @(negedge clk); check_model("rst_seq_req"); tick();
    s_ack = 1;
    @(negedge clk); check_model("rst_seq_beat");
    #2 rst_n = 0;
    #1 model_reset();
    check("rst_async", {60'd0, o_grant[0], o_grant[1]}, 64'd0);
    check("rst_async_cyc", {62'd0, o_cyc[0], o_cyc[1]}, 64'd0);
    check_model("rst_async_model");
    s_ack = 0; d_cyc = 1; d_stb = 1;
    tick();
    rst_n = 1;
    @(negedge clk);
    check("rst_release_idle", {60'd0, o_grant[0], o_grant[1]}, 64'd0);
    tick();
    @(negedge clk);
    check("rst_release_grant", {60'd0, o_grant[0], o_grant[1]}, {60'd0, 2'b10, 2'b10});
    check_model("rst_release_model");
    tick();
    clear_inputs();
    tick();
    tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      if (i_cyc) begin
        if ($urandom_range(0, 3) == 0) i_cyc = 0;
      end else if ($urandom_range(0, 2) == 0) i_cyc = 1;
      if (d_cyc) begin
        if ($urandom_range(0, 3) == 0) d_cyc = 0;
      end else if ($urandom_range(0, 2) == 0) d_cyc = 1;
      i_stb = i_cyc & ($urandom_range(0, 3) != 0);
      d_stb = d_cyc & ($urandom_range(0, 3) != 0);
      i_adr = $urandom; d_adr = $urandom; i_dat = $urandom; d_dat = $urandom;
      i_sel = 4'($urandom); d_sel = 4'($urandom); i_we = 1'($urandom); d_we = 1'($urandom);
      case ($urandom_range(0, 2))
        0: i_cti = 3'b000;
        1: i_cti = 3'b010;
        default: i_cti = 3'b111;
      endcase
      d_cti = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b111;
      begin
        int r;
        r = $urandom_range(0, 7);
        s_ack = (r < 4); s_err = (r == 4); s_rty = (r == 5);
      end
      if (streak[0] >= 4 || streak[1] >= 4) begin
        s_ack = 1; s_err = 0; s_rty = 0;
      end
      s_dat = $urandom;
      @(negedge clk);
      check_model("random");
      tick();
    end

`ifdef WB_ARB_TIMEOUT_EN
    clear_inputs();
    tick();
    tick();
    d_cyc = 1; d_stb = 1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0)
        check("to_req", {60'd0, o_grant[0], o_grant[1]}, 64'd0);
      else if (k <= 8)
        check($sformatf("to_wait%0d", k), {58'd0, o_derr[0], o_derr[1], o_grant[0], o_grant[1]},
              {58'd0, 1'b0, 1'b0, 2'b10, 2'b10});
      else if (k == 9)
        check("to_err", {60'd0, o_derr[0], o_derr[1], o_cyc[0], o_cyc[1]}, {60'd0, 4'b1100});
      else
        check($sformatf("to_abort%0d", k), {60'd0, o_derr[0], o_derr[1], o_cyc[0], o_cyc[1]}, 64'd0);
      tick();
    end
    d_cyc = 0; d_stb = 0;
    tick();
    d_cyc = 1; d_stb = 1;
    @(negedge clk);
    check("to_idle", {60'd0, o_grant[0], o_grant[1]}, 64'd0);
    tick();
    @(negedge clk);
    check("to_regrant", {60'd0, o_grant[0], o_grant[1]}, {60'd0, 2'b10, 2'b10});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_cpu_bus_arbiter.md
Name: wb_cpu_bus_arbiter

Overview:
- Two-master to one-slave Wishbone B3 arbiter for the CPU wrapper's instruction and data master buses.
- Used when a SoC variant has a single shared bus.
- Instruction and data buses from the CPU wrapper connect to the arbiter's slave ports; one master port drives the interconnect.
- Grant is held for a whole cycle (CYC) and supports incrementing bursts.

Parameters:
- ADDRESS_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; SEL width is DATA_WIDTH/8.
- DATA_PRIORITY, 1: 1 = data bus wins simultaneous requests from IDLE; 0 = round-robin.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only with WB_ARB_TIMEOUT_EN.

Ports:
clk_i  in  1  system clock; all logic rising-edge
rst_n_i  in  1  reset, asynchronous assert, active-low
iwbs_adr_i / dwbs_adr_i  in  ADDRESS_WIDTH  instruction/data master address
iwbs_dat_i / dwbs_dat_i  in  DATA_WIDTH  master write data
iwbs_sel_i / dwbs_sel_i  in  DATA_WIDTH/8  byte selects
iwbs_we_i / dwbs_we_i  in  1  write enable
iwbs_cti_i / dwbs_cti_i  in  3  cycle type
iwbs_cyc_i / dwbs_cyc_i  in  1  cycle request
iwbs_stb_i / dwbs_stb_i  in  1  strobe
iwbs_dat_o / dwbs_dat_o  out  DATA_WIDTH  read data (wbm_dat_i broadcast)
iwbs_ack_o / dwbs_ack_o  out  1  ack, gated by grant
iwbs_err_o / dwbs_err_o  out  1  error, gated by grant
iwbs_rty_o / dwbs_rty_o  out  1  retry, gated by grant
wbm_adr_o  out  ADDRESS_WIDTH  shared bus address
wbm_dat_o  out  DATA_WIDTH  shared write data
wbm_sel_o  out  DATA_WIDTH/8  shared byte selects
wbm_we_o / wbm_cti_o  out  1 / 3  shared WE, CTI
wbm_cyc_o / wbm_stb_o  out  1  shared CYC, STB
wbm_dat_i  in  DATA_WIDTH  slave read data
wbm_ack_i / wbm_err_i / wbm_rty_i  in  1  slave terminations
grant_o  out  2  registered one-hot grant: [0] instruction, [1] data; 2'b00 when idle

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D (registered); plus ABORT when the timeout feature is compiled in. Reset state IDLE.
- Reset values:
  - grant_o = 0.
  - All wbm_* outputs 0; wbm_cyc_o = wbm_stb_o = 0.
  - All master-side ack/err/rty = 0.
- IDLE transitions:
  - Only iwbs_cyc_i -> GNT_I. Only dwbs_cyc_i -> GNT_D.
  - Both requesting:
    - DATA_PRIORITY=1 -> GNT_D.
    - Else the master not granted last goes (last_gnt register, reset = instruction, so data wins first tie).
- Arbitration latency: exactly 1 cycle from CYC rising in IDLE to wbm_cyc_o.
- GNT_x datapath:
  - wbm_adr/dat/sel/we/cti/cyc/stb driven combinationally from master x.
  - Slave ack/err/rty routed only to master x; the other master sees 0.
- Release:
  - Release happens on the first cycle the granted master's CYC is low.
  - If the other master's CYC is high at that edge, it is granted directly (GNT_I <-> GNT_D, no IDLE cycle). Else -> IDLE.
- No preemption: grant is held across bursts (cti 3'b010) and across multiple STB phases while CYC stays high.
- Mid-cycle request from the other master waits; its ack/err/rty stay 0.
- last_gnt updates on every grant.
- Reset asserted mid-transfer: immediately IDLE, outputs forced to reset values asynchronously.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on grant change and on any wbm_ack_i/err_i/rty_i.
  - It increments while wbm_stb_o=1 with no termination.
  - At count == TIMEOUT_CYCLES: one-cycle err_o pulse to the granted master, wbm_cyc_o/wbm_stb_o forced 0, FSM -> ABORT.
  - ABORT holds wbm_cyc_o=0 until the aborted master drops CYC, then IDLE.
- Without the macro: no counter, no ABORT state; a hung slave stalls the bus indefinitely.

Test Plan:
- Reset, then iwbs_cyc/stb=1, adr=0x100 -> grant_o=2'b01 after 1 cycle; wbm_adr_o=0x100; slave ack reaches iwbs_ack_o only.
- Both CYC rise same cycle, DATA_PRIORITY=1 -> grant_o=2'b10; after data CYC drops, next edge grant_o=2'b01 with no idle cycle.
- DATA_PRIORITY=0, both requesting continuously with single-beat cycles -> grants alternate 01,10,01,10.
- Instruction 4-beat burst (cti 010,010,010,111) while data requests at beat 2 -> data waits; dwbs_ack_o=0 until grant_o=2'b10 after burst CYC drop.
- rst_n_i low mid-burst -> same cycle wbm_cyc_o=0, grant_o=0; after release, pending request granted 1 cycle later.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> dwbs_err_o pulses once 8 cycles after STB; wbm_cyc_o=0 until dwbs_cyc_i drops.
